friscv_mpram: RTL and testbench

Parametrised multi-port RAM that succeeds the two-port array. It provides 1 to 4 symmetric ports, each with byte-enable writes, a valid/ready request handshake, a configurable read-latency pipeline and rvalid tagging. Address collisions between ports are resolved deterministically. It sits behind the instruction/data memory adapters and the register-file-like scratch storage, where more than two agents share one array.

---
 rtl/friscv_mpram_pkg.sv | 18 +
 rtl/friscv_mpram_rdpipe.sv | 39 +++
 rtl/friscv_mpram.sv | 84 ++++++++
 tb/tb_friscv_mpram.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/friscv_mpram_pkg.sv
// Shared constants and elaboration helpers for the friscv_mpram multi-port RAM.
package friscv_mpram_pkg;

   localparam int MAX_PORT       = 4;
   localparam int MAX_RD_LATENCY = 3;

   function automatic int strb_width(input int data_width);
      return data_width / 8;
   endfunction

   function automatic bit params_legal(input int nb_port, input int data_width,
                                       input int rd_latency);
      return (nb_port >= 1) && (nb_port <= MAX_PORT) &&
             (data_width >= 8) && ((data_width % 8) == 0) &&
             (rd_latency >= 1) && (rd_latency <= MAX_RD_LATENCY);
   endfunction

endpackage

// File: rtl/friscv_mpram_rdpipe.sv
// Per-port read return pipeline: RD_LATENCY stages of {valid, data}, always advancing.
module friscv_mpram_rdpipe #(
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 1
)(
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  srst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic [RD_LATENCY-1:0] valid_q;
   logic [DATA_WIDTH-1:0] data_q [RD_LATENCY];

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         valid_q <= '0;
         for (int i = 0; i < RD_LATENCY; i++) data_q[i] <= '0;
      end else if (srst) begin
         valid_q <= '0;
         for (int i = 0; i < RD_LATENCY; i++) data_q[i] <= '0;
      end else begin
         // data only moves with a valid token so idle cycles keep the last result
         valid_q[0] <= in_valid;
         if (in_valid) data_q[0] <= in_data;
         for (int i = 1; i < RD_LATENCY; i++) begin
            valid_q[i] <= valid_q[i-1];
            if (valid_q[i-1]) data_q[i] <= data_q[i-1];
         end
      end
   end

   assign out_valid = valid_q[RD_LATENCY-1];
   assign out_data  = data_q[RD_LATENCY-1];

endmodule

// File: rtl/friscv_mpram.sv
// Multi-port RAM with byte-enable writes, read-first per-port pipelines and
// lowest-port-wins address arbitration when FRISCV_MPRAM_COLLISION_EN is defined.
module friscv_mpram
   import friscv_mpram_pkg::*;
#(
   parameter int NB_PORT    = 2,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 1,
   parameter int INIT       = 0
)(
   input  logic                              aclk,
   input  logic                              aresetn,
   input  logic                              srst,
   input  logic [NB_PORT-1:0]                en,
   input  logic [NB_PORT-1:0]                wr,
   input  logic [NB_PORT*ADDR_WIDTH-1:0]     addr,
   input  logic [NB_PORT*DATA_WIDTH/8-1:0]   strb,
   input  logic [NB_PORT*DATA_WIDTH-1:0]     wdata,
   output logic [NB_PORT-1:0]                ready,
   output logic [NB_PORT*DATA_WIDTH-1:0]     rdata,
   output logic [NB_PORT-1:0]                rvalid
);

   localparam int STRB_WIDTH = strb_width(DATA_WIDTH);
   localparam int DEPTH      = 2 ** ADDR_WIDTH;
   localparam logic [DATA_WIDTH-1:0] MEM_INIT = (INIT != 0) ? '0 : 'x;

   if (!params_legal(NB_PORT, DATA_WIDTH, RD_LATENCY)) begin : g_bad_params
      $error("friscv_mpram: illegal NB_PORT/DATA_WIDTH/RD_LATENCY");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: MEM_INIT};
   logic [NB_PORT-1:0]    wr_go;
   logic [NB_PORT-1:0]    rd_go;

   assign wr_go = en & ready & wr;
   assign rd_go = en & ready & ~wr;

`ifdef FRISCV_MPRAM_COLLISION_EN
   for (genvar j = 0; j < NB_PORT; j++) begin : g_arb
      logic [NB_PORT-1:0] block;
      for (genvar i = 0; i < NB_PORT; i++) begin : g_pair
         if (i < j) begin : g_lower
            assign block[i] = en[i] & en[j] & (wr[i] | wr[j]) &
                              (addr[i*ADDR_WIDTH +: ADDR_WIDTH] == addr[j*ADDR_WIDTH +: ADDR_WIDTH]);
         end else begin : g_none
            assign block[i] = 1'b0;
         end
      end
      assign ready[j] = ~|block;
   end
`else
   assign ready = '1;
`endif

   // Highest port is applied first so the lowest index lands last and wins per byte.
   always_ff @(posedge aclk) begin
      for (int p = NB_PORT - 1; p >= 0; p--) begin
         if (wr_go[p]) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
               if (strb[p*STRB_WIDTH + b])
                  mem[addr[p*ADDR_WIDTH +: ADDR_WIDTH]][b*8 +: 8] <= wdata[p*DATA_WIDTH + b*8 +: 8];
            end
         end
      end
   end

   for (genvar p = 0; p < NB_PORT; p++) begin : g_port
      friscv_mpram_rdpipe #(
         .DATA_WIDTH (DATA_WIDTH),
         .RD_LATENCY (RD_LATENCY)
      ) u_rdpipe (
         .aclk      (aclk),
         .aresetn   (aresetn),
         .srst      (srst),
         .in_valid  (rd_go[p]),
         .in_data   (mem[addr[p*ADDR_WIDTH +: ADDR_WIDTH]]),
         .out_valid (rvalid[p]),
         .out_data  (rdata[p*DATA_WIDTH +: DATA_WIDTH])
      );
   end

endmodule

// File: tb/tb_friscv_mpram.sv
// Directed bench for friscv_mpram: three instances cover latency 1, 3 (4 ports) and 2.
module tb_friscv_mpram;

   logic aclk = 1'b0;
   logic aresetn;
   logic srst;
   int   checks = 0;
   int   errors = 0;

   always #5 aclk = ~aclk;

   logic [1:0]   a_en, a_wr, a_ready, a_rvalid;
   logic [15:0]  a_addr;
   logic [7:0]   a_strb;
   logic [63:0]  a_wdata, a_rdata;

   logic [3:0]   b_en, b_wr, b_ready, b_rvalid;
   logic [31:0]  b_addr;
   logic [15:0]  b_strb;
   logic [127:0] b_wdata, b_rdata;

   logic         c_en, c_wr, c_ready, c_rvalid;
   logic [7:0]   c_addr;
   logic [3:0]   c_strb;
   logic [31:0]  c_wdata, c_rdata;

   friscv_mpram #(.NB_PORT(2), .ADDR_WIDTH(8), .DATA_WIDTH(32), .RD_LATENCY(1), .INIT(1)) dut_a (
      .aclk(aclk), .aresetn(aresetn), .srst(srst), .en(a_en), .wr(a_wr), .addr(a_addr),
      .strb(a_strb), .wdata(a_wdata), .ready(a_ready), .rdata(a_rdata), .rvalid(a_rvalid));

   friscv_mpram #(.NB_PORT(4), .ADDR_WIDTH(8), .DATA_WIDTH(32), .RD_LATENCY(3), .INIT(1)) dut_b (
      .aclk(aclk), .aresetn(aresetn), .srst(srst), .en(b_en), .wr(b_wr), .addr(b_addr),
      .strb(b_strb), .wdata(b_wdata), .ready(b_ready), .rdata(b_rdata), .rvalid(b_rvalid));

   friscv_mpram #(.NB_PORT(1), .ADDR_WIDTH(8), .DATA_WIDTH(32), .RD_LATENCY(2), .INIT(1)) dut_c (
      .aclk(aclk), .aresetn(aresetn), .srst(srst), .en(c_en), .wr(c_wr), .addr(c_addr),
      .strb(c_strb), .wdata(c_wdata), .ready(c_ready), .rdata(c_rdata), .rvalid(c_rvalid));

   task automatic next_cycle();
      @(posedge aclk);
      #1;
   endtask

   task automatic idle_all();
      a_en = '0; a_wr = '0; a_addr = '0; a_strb = '0; a_wdata = '0;
      b_en = '0; b_wr = '0; b_addr = '0; b_strb = '0; b_wdata = '0;
      c_en = '0; c_wr = '0; c_addr = '0; c_strb = '0; c_wdata = '0;
   endtask

   task automatic test_reset();
      aresetn = 1'b0; srst = 1'b0; idle_all();
      repeat (3) next_cycle();
      aresetn = 1'b1;
      next_cycle();
      checks++; if (a_rvalid !== 2'b00) begin errors++; $display("FAIL reset_a_rvalid: got %b expected 00", a_rvalid); end
      checks++; if (a_rdata !== 64'h0) begin errors++; $display("FAIL reset_a_rdata: got %h expected 0", a_rdata); end
      checks++; if (a_ready !== 2'b11) begin errors++; $display("FAIL reset_a_ready: got %b expected 11", a_ready); end
      checks++; if (b_rvalid !== 4'h0) begin errors++; $display("FAIL reset_b_rvalid: got %b expected 0000", b_rvalid); end
      checks++; if (b_rdata !== 128'h0) begin errors++; $display("FAIL reset_b_rdata: got %h expected 0", b_rdata); end
      checks++; if (b_ready !== 4'hF) begin errors++; $display("FAIL reset_b_ready: got %b expected 1111", b_ready); end
      checks++; if (c_rvalid !== 1'b0 || c_rdata !== 32'h0) begin errors++; $display("FAIL reset_c: got rvalid=%b rdata=%h expected 0/0", c_rvalid, c_rdata); end
   endtask

   task automatic test_byte_strobe();
      a_en = 2'b01; a_wr = 2'b01; a_addr = 16'h0010; a_strb = 8'h0F; a_wdata = 64'hAABBCCDD;
      next_cycle();
      a_strb = 8'h05; a_wdata = 64'h11223344;
      next_cycle();
      a_strb = 8'h00; a_wdata = 64'hFFFFFFFF;
      next_cycle();
      a_en = 2'b10; a_wr = 2'b00; a_addr = 16'h1000; a_strb = 8'h00; a_wdata = '0;
      #1;
      checks++; if (a_ready !== 2'b11) begin errors++; $display("FAIL strobe_read_ready: got %b expected 11", a_ready); end
      checks++; if (a_rvalid !== 2'b00) begin errors++; $display("FAIL strobe_early_rvalid: got %b expected 00", a_rvalid); end
      next_cycle();
      idle_all();
      checks++; if (a_rvalid !== 2'b10) begin errors++; $display("FAIL strobe_rvalid: got %b expected 10", a_rvalid); end
      checks++; if (a_rdata[63:32] !== 32'hAA22CC44) begin errors++; $display("FAIL strobe_rdata: got %h expected aa22cc44", a_rdata[63:32]); end
      next_cycle();
      checks++; if (a_rvalid !== 2'b00) begin errors++; $display("FAIL strobe_rvalid_pulse: got %b expected 00", a_rvalid); end
   endtask

   task automatic test_write_collision();
      a_en = 2'b11; a_wr = 2'b11; a_addr = 16'h2020; a_strb = 8'hFF; a_wdata = {32'h2, 32'h1};
      #1;
`ifdef FRISCV_MPRAM_COLLISION_EN
      checks++; if (a_ready !== 2'b01) begin errors++; $display("FAIL wcoll_ready: got %b expected 01", a_ready); end
      next_cycle();
      a_en = 2'b10;
      #1;
      checks++; if (a_ready !== 2'b11) begin errors++; $display("FAIL wcoll_retry_ready: got %b expected 11", a_ready); end
      next_cycle();
`else
      checks++; if (a_ready !== 2'b11) begin errors++; $display("FAIL wcoll_ready: got %b expected 11", a_ready); end
      next_cycle();
`endif
      a_en = 2'b01; a_wr = 2'b00; a_addr = 16'h0020; a_strb = '0; a_wdata = '0;
      next_cycle();
      idle_all();
`ifdef FRISCV_MPRAM_COLLISION_EN
      checks++; if (a_rvalid !== 2'b01 || a_rdata[31:0] !== 32'h2) begin errors++; $display("FAIL wcoll_result: got rvalid=%b rdata=%h expected 01/2", a_rvalid, a_rdata[31:0]); end
`else
      checks++; if (a_rvalid !== 2'b01 || a_rdata[31:0] !== 32'h1) begin errors++; $display("FAIL wcoll_result: got rvalid=%b rdata=%h expected 01/1", a_rvalid, a_rdata[31:0]); end
`endif
   endtask

   task automatic test_rw_collision();
      a_en = 2'b01; a_wr = 2'b01; a_addr = 16'h0030; a_strb = 8'h0F; a_wdata = 64'h5;
      next_cycle();
      a_en = 2'b11; a_wr = 2'b01; a_addr = 16'h3030; a_strb = 8'h0F; a_wdata = {32'h0, 32'h9};
      #1;
`ifdef FRISCV_MPRAM_COLLISION_EN
      checks++; if (a_ready !== 2'b01) begin errors++; $display("FAIL rwcoll_ready: got %b expected 01", a_ready); end
      next_cycle();
      checks++; if (a_rvalid !== 2'b00) begin errors++; $display("FAIL rwcoll_stall_rvalid: got %b expected 00", a_rvalid); end
      a_en = 2'b10; a_wr = 2'b00; a_strb = '0;
      #1;
      checks++; if (a_ready !== 2'b11) begin errors++; $display("FAIL rwcoll_retry_ready: got %b expected 11", a_ready); end
      next_cycle();
      idle_all();
      checks++; if (a_rvalid !== 2'b10 || a_rdata[63:32] !== 32'h9) begin errors++; $display("FAIL rwcoll_result: got rvalid=%b rdata=%h expected 10/9", a_rvalid, a_rdata[63:32]); end
`else
      checks++; if (a_ready !== 2'b11) begin errors++; $display("FAIL rwcoll_ready: got %b expected 11", a_ready); end
      next_cycle();
      idle_all();
      checks++; if (a_rvalid !== 2'b10 || a_rdata[63:32] !== 32'h5) begin errors++; $display("FAIL rwcoll_result: got rvalid=%b rdata=%h expected 10/5", a_rvalid, a_rdata[63:32]); end
`endif
      // read/read to one address never conflicts
      a_en = 2'b11; a_wr = 2'b00; a_addr = 16'h3030;
      #1;
      checks++; if (a_ready !== 2'b11) begin errors++; $display("FAIL rr_ready: got %b expected 11", a_ready); end
      next_cycle();
      idle_all();
      checks++; if (a_rvalid !== 2'b11 || a_rdata !== {32'h9, 32'h9}) begin errors++; $display("FAIL rr_result: got rvalid=%b rdata=%h expected 11/0000000900000009", a_rvalid, a_rdata); end
   endtask

   task automatic test_throughput();
      logic [3:0] exp_v;
      for (int k = 0; k < 8; k++) begin
         b_en = 4'hF; b_wr = 4'hF; b_strb = 16'hFFFF;
         for (int p = 0; p < 4; p++) begin
            b_addr[p*8 +: 8]   = 8'(p*16 + k);
            b_wdata[p*32 +: 32] = 32'hC0DE0000 | 32'(p << 8) | 32'(k);
         end
         next_cycle();
      end
      for (int c = 0; c < 12; c++) begin
         if (c < 8) begin
            b_en = 4'hF; b_wr = 4'h0; b_strb = '0; b_wdata = '0;
            for (int p = 0; p < 4; p++) b_addr[p*8 +: 8] = 8'(p*16 + c);
         end else begin
            b_en = 4'h0; b_wr = 4'h0; b_addr = '0;
         end
         #1;
         if (c < 8) begin
            checks++; if (b_ready !== 4'hF) begin errors++; $display("FAIL tput_ready c=%0d: got %b expected 1111", c, b_ready); end
         end
         exp_v = (c >= 3 && c <= 10) ? 4'hF : 4'h0;
         checks++; if (b_rvalid !== exp_v) begin errors++; $display("FAIL tput_rvalid c=%0d: got %b expected %b", c, b_rvalid, exp_v); end
         if (c >= 3 && c <= 10) begin
            for (int p = 0; p < 4; p++) begin
               checks++;
               if (b_rdata[p*32 +: 32] !== (32'hC0DE0000 | 32'(p << 8) | 32'(c - 3))) begin
                  errors++;
                  $display("FAIL tput_rdata c=%0d p=%0d: got %h expected %h", c, p, b_rdata[p*32 +: 32],
                           32'hC0DE0000 | 32'(p << 8) | 32'(c - 3));
               end
            end
         end
         next_cycle();
      end
      idle_all();
   endtask

   task automatic test_midflight_reset();
      c_en = 1'b1; c_wr = 1'b1; c_addr = 8'h05; c_strb = 4'hF; c_wdata = 32'h5A5A5A5A;
      next_cycle();
      c_wr = 1'b0; c_strb = '0; c_wdata = '0;
      next_cycle();
      idle_all();
      checks++; if (c_rvalid !== 1'b0) begin errors++; $display("FAIL lat2_early_rvalid: got %b expected 0", c_rvalid); end
      next_cycle();
      checks++; if (c_rvalid !== 1'b1 || c_rdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL lat2_result: got rvalid=%b rdata=%h expected 1/5a5a5a5a", c_rvalid, c_rdata); end
      next_cycle();
      c_en = 1'b1; c_wr = 1'b0; c_addr = 8'h05;
      next_cycle();
      idle_all();
      srst = 1'b1;
      next_cycle();
      srst = 1'b0;
      checks++; if (c_rvalid !== 1'b0 || c_rdata !== 32'h0) begin errors++; $display("FAIL srst_drop: got rvalid=%b rdata=%h expected 0/0", c_rvalid, c_rdata); end
      next_cycle();
      checks++; if (c_rvalid !== 1'b0 || c_rdata !== 32'h0) begin errors++; $display("FAIL srst_drop_late: got rvalid=%b rdata=%h expected 0/0", c_rvalid, c_rdata); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_byte_strobe();
      test_write_collision();
      test_rw_collision();
      test_throughput();
      test_midflight_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
